// File: rtl/image_pkg.sv
// Shared kernel codes, box-filter constants and controller states for the
// streaming image filter.
package image_pkg;

    typedef enum logic [1:0] {
        KERNEL_IDENTITY = 2'd0,
        KERNEL_GAUSS    = 2'd1,
        KERNEL_SHARPEN  = 2'd2,
        KERNEL_BOX      = 2'd3
    } kernel_e;

    // Box average approximated as sum9 * 57 / 512 (57/512 ~= 1/9).
    localparam int BOX_MUL   = 57;
    localparam int BOX_SHIFT = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Width of a counter or index for n distinct values (at least one bit).
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/image_line_buffer.sv
// Enable-gated delay line: synchronous-read RAM of DEPTH entries behind a
// wrap-around pointer; dout is the sample pushed DEPTH enables earlier.
module image_line_buffer
    import image_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    localparam int AW = bits_for(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     ptr_q;
    logic [DATA_W-1:0] dout_q;

    // NOTE: the RAM has no reset so it maps onto block memory; any entry read
    // before being written only feeds window taps the border clamp discards.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    // Read-before-write on the same address yields the value from DEPTH pushes ago.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            dout_q <= '0;
        end else if (en_i) begin
            dout_q <= mem_q[ptr_q];
            ptr_q  <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/image_filter_stream.sv
// Streaming 3x3 per-channel convolution over raster-order, channel-interleaved
// samples with edge-replicate borders, valid/ready flow control and flush.
module image_filter_stream
    import image_pkg::*;
#(
    parameter int WIDTH    = 788,
    parameter int HEIGHT   = 1080,
    parameter int CHANNELS = 3,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        kernel_type,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int ROW_LEN   = WIDTH * CHANNELS;
    localparam int LAG       = ROW_LEN + CHANNELS;
    localparam int N_SAMPLES = ROW_LEN * HEIGHT;
    localparam int TOTAL     = N_SAMPLES + LAG;
    localparam int PW        = bits_for(TOTAL);
    localparam int OW        = bits_for(N_SAMPLES);
    localparam int CHW       = bits_for(CHANNELS);
    localparam int COLW      = bits_for(WIDTH);
    localparam int ROWW      = bits_for(HEIGHT);
    localparam int ACC_W     = DATA_W + 4;
    localparam int PROD_W    = DATA_W + 10;
    localparam int SR_LEN    = 2 * CHANNELS;

    typedef logic [DATA_W-1:0] sample_t;

    state_e          state_q, state_d;
    kernel_e         kernel_q, kernel_d;
    logic [PW-1:0]   push_cnt_q, push_cnt_d;
    logic [OW-1:0]   out_cnt_q, out_cnt_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic            done_q, done_d;

    logic    stall, push, emit, out_fire;
    sample_t push_data, mid_new, top_new;
    sample_t bot_sr_q [SR_LEN];
    sample_t mid_sr_q [SR_LEN];
    sample_t top_sr_q [SR_LEN];
    sample_t raw   [3][3];
    sample_t win_d [3][3];
    sample_t win_q [3][3];
    logic [1:0] rsel [3];
    logic [1:0] csel [3];
    logic    w_valid_q, out_valid_q;
    sample_t out_data_q, filt;

    assign stall     = out_valid_q && !out_ready;
    assign push      = !stall && ((state_q == RUN && in_valid) || state_q == FLUSH);
    assign push_data = (state_q == RUN) ? in_data : '0;
    assign emit      = push && (push_cnt_q >= PW'(LAG));
    assign out_fire  = out_valid_q && out_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        kernel_d   = kernel_q;
        push_cnt_d = push_cnt_q;
        out_cnt_d  = out_cnt_q;
        ch_d       = ch_q;
        col_d      = col_q;
        row_d      = row_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    kernel_d   = kernel_e'(kernel_type);
                    state_d    = RUN;
                    push_cnt_d = '0;
                    out_cnt_d  = '0;
                    ch_d       = '0;
                    col_d      = '0;
                    row_d      = '0;
                end
            end
            RUN: begin
                if (push && push_cnt_q == PW'(N_SAMPLES - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (push && push_cnt_q == PW'(TOTAL - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_cnt_q == OW'(N_SAMPLES - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            push_cnt_d = push_cnt_q + PW'(1);
        end
        if (out_fire) begin
            out_cnt_d = out_cnt_q + OW'(1);
        end
        // Coordinates track the sample whose window completes on this push.
        if (emit) begin
            if (ch_q == CHW'(CHANNELS - 1)) begin
                ch_d = '0;
                if (col_q == COLW'(WIDTH - 1)) begin
                    col_d = '0;
                    row_d = row_q + ROWW'(1);
                end else begin
                    col_d = col_q + COLW'(1);
                end
            end else begin
                ch_d = ch_q + CHW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            kernel_q   <= KERNEL_IDENTITY;
            push_cnt_q <= '0;
            out_cnt_q  <= '0;
            ch_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kernel_q   <= kernel_d;
            push_cnt_q <= push_cnt_d;
            out_cnt_q  <= out_cnt_d;
            ch_q       <= ch_d;
            col_q      <= col_d;
            row_q      <= row_d;
            done_q     <= done_d;
        end
    end

    // Line buffers are one entry short: their output register is the row's last slot.
    image_line_buffer #(.DEPTH(ROW_LEN - 1), .DATA_W(DATA_W)) u_lb_mid (
        .clk    (clk),
        .reset  (reset),
        .en_i   (push),
        .din_i  (push_data),
        .dout_o (mid_new)
    );

    image_line_buffer #(.DEPTH(ROW_LEN - 1), .DATA_W(DATA_W)) u_lb_top (
        .clk    (clk),
        .reset  (reset),
        .en_i   (push),
        .din_i  (mid_new),
        .dout_o (top_new)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SR_LEN; i++) begin
                bot_sr_q[i] <= '0;
                mid_sr_q[i] <= '0;
                top_sr_q[i] <= '0;
            end
        end else if (push) begin
            bot_sr_q[0] <= push_data;
            mid_sr_q[0] <= mid_new;
            top_sr_q[0] <= top_new;
            for (int i = 1; i < SR_LEN; i++) begin
                bot_sr_q[i] <= bot_sr_q[i-1];
                mid_sr_q[i] <= mid_sr_q[i-1];
                top_sr_q[i] <= top_sr_q[i-1];
            end
        end
    end

    // Same-channel neighbours sit CHANNELS apart; column 2 is the newest.
    always_comb begin
        raw[0][0] = top_sr_q[SR_LEN-1];
        raw[0][1] = top_sr_q[CHANNELS-1];
        raw[0][2] = top_new;
        raw[1][0] = mid_sr_q[SR_LEN-1];
        raw[1][1] = mid_sr_q[CHANNELS-1];
        raw[1][2] = mid_new;
        raw[2][0] = bot_sr_q[SR_LEN-1];
        raw[2][1] = bot_sr_q[CHANNELS-1];
        raw[2][2] = push_data;

        rsel[0] = (row_q == '0) ? 2'd1 : 2'd0;
        rsel[1] = 2'd1;
        rsel[2] = (row_q == ROWW'(HEIGHT - 1)) ? 2'd1 : 2'd2;
        csel[0] = (col_q == '0) ? 2'd1 : 2'd0;
        csel[1] = 2'd1;
        csel[2] = (col_q == COLW'(WIDTH - 1)) ? 2'd1 : 2'd2;

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_d[i][j] = raw[rsel[i]][csel[j]];
            end
        end
    end

    function automatic logic [ACC_W-1:0] ext(input sample_t s);
        return ACC_W'(s);
    endfunction

    logic [ACC_W-1:0]        gsum, bsum;
    logic signed [ACC_W-1:0] ssum;
    logic [PROD_W-1:0]       bprod, bq;

    always_comb begin
        gsum = ext(win_q[0][0]) + (ext(win_q[0][1]) << 1) + ext(win_q[0][2])
             + (ext(win_q[1][0]) << 1) + (ext(win_q[1][1]) << 2) + (ext(win_q[1][2]) << 1)
             + ext(win_q[2][0]) + (ext(win_q[2][1]) << 1) + ext(win_q[2][2])
             + ACC_W'(8);
        ssum = signed'((ext(win_q[1][1]) << 2) + ext(win_q[1][1])
             - ext(win_q[0][1]) - ext(win_q[2][1]) - ext(win_q[1][0]) - ext(win_q[1][2]));
        bsum = ext(win_q[0][0]) + ext(win_q[0][1]) + ext(win_q[0][2])
             + ext(win_q[1][0]) + ext(win_q[1][1]) + ext(win_q[1][2])
             + ext(win_q[2][0]) + ext(win_q[2][1]) + ext(win_q[2][2]);
        bprod = PROD_W'(bsum) * PROD_W'(BOX_MUL) + PROD_W'(1 << (BOX_SHIFT - 1));
        bq    = bprod >> BOX_SHIFT;
        filt  = win_q[1][1];

        case (kernel_q)
            KERNEL_IDENTITY: filt = win_q[1][1];
            KERNEL_GAUSS:    filt = sample_t'(gsum >> 4);
            KERNEL_SHARPEN: begin
                if (ssum < 0) begin
                    filt = '0;
                end else if (ssum > signed'(ACC_W'((1 << DATA_W) - 1))) begin
                    filt = '1;
                end else begin
                    filt = sample_t'(ssum);
                end
            end
            KERNEL_BOX: filt = (bq > PROD_W'((1 << DATA_W) - 1)) ? '1 : sample_t'(bq);
        endcase
    end

    // Window register then output register: two cycles from completing push to out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_valid_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else if (!stall) begin
            w_valid_q   <= emit;
            out_valid_q <= w_valid_q;
            if (emit) begin
                win_q <= win_d;
            end
            if (w_valid_q) begin
                out_data_q <= filt;
            end
        end
    end

    assign in_ready  = (state_q == RUN) && !stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: doc/image_filter_stream.md
Name: image_filter_stream

Overview:
- Streaming 3x3 per-channel convolution filter for raster-order, channel-interleaved images (R,G,B,R,G,B,...), one sample per transfer.
- Successor to the fixed-size blur block:
  - parametrised in image size, channel count and sample width;
  - adds valid/ready flow control on both sides, four kernel modes, edge-replicate borders and an end-of-frame flush.
- Sits between the image source/memory loader and the output writer in the image pipeline.

Parameters:
- WIDTH, 788, pixels per row (>=2)
- HEIGHT, 1080, rows per frame (>=2)
- CHANNELS, 3, interleaved samples per pixel (>=1)
- DATA_W, 8, bits per sample

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a frame when idle
- kernel_type  in  2  filter mode, sampled on the accepted start
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  DATA_W  input sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  DATA_W  filtered sample
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last output transferred

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0; all counters zero; state IDLE.
- Reset is honoured in any state, including mid-frame. The partial frame is discarded and no done is issued.
- N = WIDTH*HEIGHT*CHANNELS. Exactly N inputs are accepted and exactly N outputs emitted per frame, in input order.
- State machine:
  - IDLE: start -> latch kernel_type, go to FILL, busy=1.
  - FILL/RUN: in_ready=1 unless the pipeline is stalled. A transfer occurs on in_valid&&in_ready. After the Nth accepted input -> FLUSH.
  - FLUSH: in_ready=0. The block self-injects L = WIDTH*CHANNELS+CHANNELS dummy pushes, one per unstalled cycle -> DRAIN.
  - DRAIN: wait for the final output transfer, pulse done for 1 cycle -> IDLE.
- start while busy is ignored; kernel_type is not re-sampled.
- Window timing: output k is computed when push k+L occurs (real or flush), i.e. when the same-channel sample at (row+1, col+1) is present. The compute pipeline is 2 cycles from that push to out_valid.
- Stall: when out_valid&&!out_ready, the whole pipeline holds. Held state covers the line buffers, window and flush counter; in_ready=0. No sample may be lost or duplicated.
- Borders: coordinates are clamped (edge replicate).
  - Row -1 -> row 0; row HEIGHT -> row HEIGHT-1.
  - Col -1 -> col 0; col WIDTH -> col WIDTH-1.
  - Channels never mix.
- Kernels (unsigned sample p, window w[i][j]):
  - 0 identity: out = centre.
  - 1 gaussian [1 2 1;2 4 2;1 2 1]: out = (sum+8)>>4; accumulator DATA_W+4 bits.
  - 2 sharpen [0 -1 0;-1 5 -1;0 -1 0]: signed accumulator DATA_W+4 bits; saturate to [0, 2^DATA_W-1].
  - 3 box: out = (sum9*57+256)>>9, saturated to 2^DATA_W-1; sum9 is DATA_W+4 bits, product DATA_W+10 bits.
- Storage: two row line buffers of WIDTH*CHANNELS samples each, plus a 3-column x CHANNELS shift window. Line-buffer reads have 1-cycle latency.

Decomposition:
- Shared package image_pkg holds:
  - KERNEL_IDENTITY=0, KERNEL_GAUSS=1, KERNEL_SHARPEN=2, KERNEL_BOX=3;
  - BOX_MUL=57, BOX_SHIFT=9;
  - the state encoding IDLE/RUN/FLUSH/DRAIN.
- One sub-module: image_line_buffer.
  - Parametrised DEPTH/DATA_W delay line with enable (stall) input.
  - Synchronous-read RAM plus wrap-around address counter.
  - Instantiated twice.

Test Plan:
- WIDTH=4,HEIGHT=3,CHANNELS=3, kernel 0, ramp 0..35, out_ready=1 -> outputs 0..35 in order; first out_valid 2 cycles after input 15 accepted; done 1 cycle after output 35.
- kernel 1, constant 100 frame -> all 36 outputs = 100, confirming border clamp and rounding.
- kernel 2, background 100 with channel-0 sample 50 at (row1,col1):
  - centre output 0 (-150 saturated);
  - its 4 channel-0 neighbours 150;
  - all other channel-0 outputs 100; channels 1,2 = 100.
- kernel 3: constant 9 frame -> all 9; constant 255 frame -> all 255 (no overflow).
- kernel 1, random frame, out_ready low for 10 cycles mid-frame and randomly toggled -> output stream identical to the no-stall reference model; in_ready=0 while stalled.
- reset mid-frame (after 20 inputs):
  - next cycle busy=out_valid=done=in_ready=0;
  - start during the following frame is ignored;
  - a fresh frame with kernel 0 afterwards reproduces its input exactly.
